matbi_tick_chain: RTL and testbench
===================================

# matbi_tick_chain

Parametrised cascade of modulo counters for the watch datapath, such as sec/min/hour in one block. Each stage has its own runtime modulus. The whole chain supports up or down counting and a synchronous preset load. Carries ripple through all stages in the same cycle, and each stage emits a one-cycle carry/borrow pulse. Stage 0 is driven by the base tick from the prescaler; the count and pulse outputs feed the display and alarm logic.

## Interface
- P_NUM_STAGE, 3: number of cascaded stages (≥1); stage 0 is least significant.
- P_COUNT_BIT, 8: count width per stage.
- P_DELAY_OUT, 0: pipeline delay in cycles applied to o_cnt_val only; 0 means bypass.
- Ports use NS = P_NUM_STAGE and CB = P_COUNT_BIT. Stage k occupies bits [k*CB +: CB] in every packed bus.
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears every register, including the delay pipeline.
- i_run_en  in  1  global enable; 0 freezes all counts.
- i_tick  in  1  base advance strobe, one cycle wide.
- i_dir  in  1  0 = count up, 1 = count down; sampled with the tick.
- i_mod  in  NS*CB  per-stage modulus M; the stage counts over 0..M-1.
- i_load  in  1  synchronous preset of all stages.
- i_load_val  in  NS*CB  preset values.
- o_tick  out  NS  registered per-stage carry/borrow pulse.
- o_cnt_val  out  NS*CB  per-stage count, delayed by P_DELAY_OUT.

## Operation
- Priority per clock edge: reset > i_load > advance > hold.
- **Load:** all stages take i_load_val unchanged, including values ≥ M. o_tick goes to 0.
- **Advance:**
  - adv[0] = i_run_en & i_tick.
  - adv[k] = adv[k-1] & wrap[k-1]. This is combinational ripple, so the full chain settles in one cycle.
- **Up mode, stage with adv:**
  - cnt ≥ M-1 → cnt = 0 and wrap = 1. This covers out-of-range values.
  - Otherwise cnt + 1 and wrap = 0.
- **Down mode, stage with adv:**
  - cnt == 0 → cnt = M-1 and wrap = 1.
  - cnt ≥ M → cnt = M-1 and wrap = 0. This recovers an out-of-range value without a borrow.
  - Otherwise cnt − 1.
- **M = 0 or 1:** the stage stays at 0, and wrap = adv (pass-through).
- **No advance:** o_tick = 0; counts hold.
- **Modulus change:** i_mod may change at any time. It takes effect on the next advance; existing counts are not clamped until that advance.
- **Arithmetic:** unsigned, CB bits, no overflow beyond M-1. M is compared in CB bits.

## Timing
- **Reset values:** all counts 0, o_tick all 0, delay registers 0. Reset acts immediately (asynchronous assertion). Deassertion is assumed synchronous to clk upstream.
- **Reset mid-operation:** the state is lost, with no partial pulse. An o_tick pulse in flight is cleared.
- **Counts:** updated at the edge that samples adv. With P_DELAY_OUT = 0 the new value is visible the next cycle.
- **o_tick[k]:** high for exactly one cycle, coincident with the wrapped count on the undelayed path.
- **o_cnt_val:** lags the internal count by P_DELAY_OUT cycles. o_tick is not delayed.
- **Back-to-back ticks:** every cycle is legal. No pulses are merged or dropped.
- **i_load with i_tick in the same cycle:** the load wins and the tick is discarded.

## Structure
- **Package matbi_tick_pkg:**
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - A function for the stage slice index.
- **Sub-module matbi_tick_stage:**
  - One modulo up/down counter with inputs adv, dir, mod, load, load_val and outputs cnt, wrap (combinational) and tick (registered).
  - Instantiated NS times in a generate loop, with adv chained.
- **Delay line:** a generate block in the top module. It is a bypass when P_DELAY_OUT = 0 and otherwise a shift register array.

## Test plan
All scenarios use NS=3 and CB=8, with mod = {24, 60, 60} for stage2..0 and P_DELAY_OUT=0 unless stated.

- **Up wrap ripple:** load {23, 59, 58}, then two ticks with i_dir=0.
  - First tick → {23, 59, 59}, o_tick = 000.
  - Second tick → {0, 0, 0}, o_tick = 111 for one cycle.
- **Down borrow ripple:** from {0, 0, 0}, one tick with i_dir=1 → {23, 59, 59}, o_tick = 111.
- **Out-of-range recovery:** mod0 = 10, load stage0 = 15.
  - Up tick → 0, o_tick[0] = 1, stage1 increments.
  - Reload 15, then down tick → 9, o_tick = 000.
- **Priority:** i_load, with i_load_val = {1, 2, 3}, asserted together with i_tick → counts {1, 2, 3}, o_tick = 000. With i_run_en = 0, 10 ticks → no change.
- **Async reset mid-count:** assert reset between edges while o_tick[0] = 1.
  - Outputs go to 0 before the next edge.
  - After release, the first tick → stage0 = 1.
- **Delay:** P_DELAY_OUT = 2, ticks on consecutive cycles.
  - o_cnt_val reproduces the internal sequence 2 cycles late.
  - o_tick stays undelayed; reset clears the pipeline to 0.

Source files
------------

// File: rtl/matbi_tick_pkg.sv
// Shared definitions for the tick chain: count direction encoding and the
// helper that locates a stage inside the packed per-stage buses.
package matbi_tick_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // LSB position of stage 'stage' in a bus of 'width'-bit stage fields
    function automatic int stage_lsb(input int stage, input int width);
        return stage * width;
    endfunction

endpackage

// File: rtl/matbi_tick_stage.sv
// One modulo up/down counter of the tick chain. o_wrap is combinational so
// the carry can ripple through every stage in the same cycle; o_tick is the
// registered carry/borrow pulse that lines up with the wrapped count.
module matbi_tick_stage
    import matbi_tick_pkg::*;
#(
    parameter int P_COUNT_BIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_adv,
    input  logic                   i_dir,
    input  logic [P_COUNT_BIT-1:0] i_mod,
    input  logic                   i_load,
    input  logic [P_COUNT_BIT-1:0] i_load_val,
    output logic [P_COUNT_BIT-1:0] o_cnt,
    output logic                   o_wrap,
    output logic                   o_tick
);

    localparam int CB = P_COUNT_BIT;
    localparam logic [CB-1:0] ONE = CB'(1);

    logic [CB-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [CB-1:0] step_cnt;
    logic [CB-1:0] mod_last;

    // Value the stage would take on an advance, and whether that advance wraps
    always_comb begin
        step_cnt = cnt_q;
        o_wrap   = 1'b0;
        mod_last = i_mod - ONE;
        if (i_mod <= ONE) begin
            // Degenerate modulus: stay at zero and pass the advance straight on
            step_cnt = '0;
            o_wrap   = i_adv;
        end else begin
            case (i_dir)
                DIR_UP: begin
                    // >= also folds out-of-range counts back to zero with a carry
                    if (cnt_q >= mod_last) begin
                        step_cnt = '0;
                        o_wrap   = i_adv;
                    end else begin
                        step_cnt = cnt_q + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (cnt_q == '0) begin
                        step_cnt = mod_last;
                        o_wrap   = i_adv;
                    end else if (cnt_q >= i_mod) begin
                        // Out-of-range count recovers to the top without a borrow
                        step_cnt = mod_last;
                    end else begin
                        step_cnt = cnt_q - ONE;
                    end
                end
            endcase
        end
    end

    // Next-state selection: load beats advance, otherwise hold
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_adv) begin
            cnt_d  = step_cnt;
            tick_d = o_wrap;
        end
    end

    // Count and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_tick = tick_q;

endmodule

// File: rtl/matbi_tick_chain.sv
// Cascade of modulo counters (e.g. sec/min/hour) with a same-cycle carry
// ripple, per-stage carry pulses and an optional output delay on the counts.
module matbi_tick_chain
    import matbi_tick_pkg::*;
#(
    parameter int P_NUM_STAGE = 3,
    parameter int P_COUNT_BIT = 8,
    parameter int P_DELAY_OUT = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_run_en,
    input  logic                               i_tick,
    input  logic                               i_dir,
    input  logic [P_NUM_STAGE*P_COUNT_BIT-1:0] i_mod,
    input  logic                               i_load,
    input  logic [P_NUM_STAGE*P_COUNT_BIT-1:0] i_load_val,
    output logic [P_NUM_STAGE-1:0]             o_tick,
    output logic [P_NUM_STAGE*P_COUNT_BIT-1:0] o_cnt_val
);

    localparam int NS = P_NUM_STAGE;
    localparam int CB = P_COUNT_BIT;
    localparam int W  = NS * CB;

    logic [NS-1:0] adv;
    logic [W-1:0]  cnt_w;

    assign adv[0] = i_run_en & i_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_stage
            localparam int LSB = stage_lsb(gi, CB);
            // Carry into the next stage; the most significant stage's carry
            // has no consumer
            logic wrap_unused;

            matbi_tick_stage #(
                .P_COUNT_BIT(CB)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .i_adv      (adv[gi]),
                .i_dir      (i_dir),
                .i_mod      (i_mod[LSB +: CB]),
                .i_load     (i_load),
                .i_load_val (i_load_val[LSB +: CB]),
                .o_cnt      (cnt_w[LSB +: CB]),
                .o_wrap     (wrap_unused),
                .o_tick     (o_tick[gi])
            );

            if (gi < NS - 1) begin : g_link
                assign adv[gi+1] = adv[gi] & wrap_unused;
            end
        end

        if (P_DELAY_OUT == 0) begin : g_bypass
            assign o_cnt_val = cnt_w;
        end else begin : g_delay
            logic [W-1:0] dly_q [P_DELAY_OUT];
            logic [W-1:0] dly_d [P_DELAY_OUT];

            // Shift the live counts one slot further down the line each cycle
            always_comb begin
                dly_d[0] = cnt_w;
                for (int i = 1; i < P_DELAY_OUT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            // Delay line registers, cleared together with the counters
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < P_DELAY_OUT; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < P_DELAY_OUT; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign o_cnt_val = dly_q[P_DELAY_OUT-1];
        end
    endgenerate

endmodule

// File: tb/tb_matbi_tick_chain.sv
// Self-checking bench: a behavioural model pushes expected counts/pulses to a
// scoreboard queue when stimulus is driven; they are popped and compared after
// the edge. A second instance with a 2-cycle output delay runs in parallel.
module tb_matbi_tick_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_run_en, i_tick, i_dir, i_load;
    logic [23:0] i_mod, i_load_val;
    logic [2:0]  o_tick, o_tick_d;
    logic [23:0] o_cnt_val, o_cnt_val_d;

    always #5 clk = ~clk;

    matbi_tick_chain #(.P_NUM_STAGE(3), .P_COUNT_BIT(8), .P_DELAY_OUT(0)) dut (
        .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_tick(i_tick), .i_dir(i_dir),
        .i_mod(i_mod), .i_load(i_load), .i_load_val(i_load_val),
        .o_tick(o_tick), .o_cnt_val(o_cnt_val)
    );

    matbi_tick_chain #(.P_NUM_STAGE(3), .P_COUNT_BIT(8), .P_DELAY_OUT(2)) dut_d (
        .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_tick(i_tick), .i_dir(i_dir),
        .i_mod(i_mod), .i_load(i_load), .i_load_val(i_load_val),
        .o_tick(o_tick_d), .o_cnt_val(o_cnt_val_d)
    );

    typedef struct packed {
        logic [23:0] cnt;
        logic [2:0]  tick;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] dly_hist[$];
    int          mcnt[3];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn = 0;

    function automatic logic [23:0] pack3(input int s2, input int s1, input int s0);
        return {8'(s2), 8'(s1), 8'(s0)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        exp_q.delete();
        dly_hist.delete();
        dly_hist.push_back(24'h0);
        dly_hist.push_back(24'h0);
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare both instances
    task automatic apply(input logic ld, input logic [23:0] lv, input logic run,
                         input logic tk, input logic dir);
        exp_t        e;
        exp_t        got;
        logic [23:0] d_exp;
        logic        a;
        int          m;
        int          c;
        logic        w;
        i_load = ld; i_load_val = lv; i_run_en = run; i_tick = tk; i_dir = dir;
        a = run & tk;
        e.tick = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m = int'(i_mod[k*8 +: 8]);
            c = mcnt[k];
            w = 1'b0;
            if (ld) begin
                c = int'(lv[k*8 +: 8]);
            end else if (a) begin
                if (m <= 1) begin
                    c = 0; w = 1'b1;
                end else if (dir == 1'b0) begin
                    if (c >= m - 1) begin c = 0; w = 1'b1; end
                    else c = c + 1;
                end else begin
                    if (c == 0) begin c = m - 1; w = 1'b1; end
                    else if (c >= m) c = m - 1;
                    else c = c - 1;
                end
                e.tick[k] = w;
                a = w;
            end
            mcnt[k] = c;
        end
        e.cnt = pack3(mcnt[2], mcnt[1], mcnt[0]);
        exp_q.push_back(e);
        dly_hist.push_back(e.cnt);
        @(posedge clk);
        #1;
        i_load = 1'b0;
        i_tick = 1'b0;
        got = exp_q.pop_front();
        d_exp = dly_hist.pop_front();
        n_txn++;
        $display("txn %0d load=%0b run=%0b tick=%0b dir=%0b cnt=%h o_tick=%b cnt_dly=%h",
                 n_txn, ld, run, tk, dir, o_cnt_val, o_tick, o_cnt_val_d);
        n_checks++;
        if (o_cnt_val !== got.cnt) begin
            n_errors++;
            $display("FAIL cnt_val txn %0d: got %h expected %h", n_txn, o_cnt_val, got.cnt);
        end
        n_checks++;
        if (o_tick !== got.tick) begin
            n_errors++;
            $display("FAIL o_tick txn %0d: got %b expected %b", n_txn, o_tick, got.tick);
        end
        n_checks++;
        if (o_cnt_val_d !== d_exp) begin
            n_errors++;
            $display("FAIL cnt_val_delayed txn %0d: got %h expected %h", n_txn, o_cnt_val_d, d_exp);
        end
        n_checks++;
        if (o_tick_d !== got.tick) begin
            n_errors++;
            $display("FAIL o_tick_delayed_inst txn %0d: got %b expected %b", n_txn, o_tick_d, got.tick);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (o_cnt_val !== 24'h0 || o_tick !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state: got cnt=%h tick=%b expected 000000/000", o_cnt_val, o_tick);
        end
        n_checks++;
        if (o_cnt_val_d !== 24'h0 || o_tick_d !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state_delayed: got cnt=%h tick=%b expected 000000/000", o_cnt_val_d, o_tick_d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_up_wrap();
        i_mod = pack3(24, 60, 60);
        apply(1'b1, pack3(23, 59, 58), 1'b1, 1'b0, 1'b0);
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(23, 59, 59) || o_tick !== 3'b000) begin
            n_errors++;
            $display("FAIL up_first_tick: got %h/%b expected 173b3b/000", o_cnt_val, o_tick);
        end
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== 24'h0 || o_tick !== 3'b111) begin
            n_errors++;
            $display("FAIL up_wrap_ripple: got %h/%b expected 000000/111", o_cnt_val, o_tick);
        end
        apply(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_down_borrow();
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (o_cnt_val !== pack3(23, 59, 59) || o_tick !== 3'b111) begin
            n_errors++;
            $display("FAIL down_borrow: got %h/%b expected 173b3b/111", o_cnt_val, o_tick);
        end
    endtask

    task automatic test_out_of_range();
        i_mod = pack3(24, 60, 10);
        apply(1'b1, pack3(0, 0, 15), 1'b1, 1'b0, 1'b0);
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(0, 1, 0) || o_tick !== 3'b001) begin
            n_errors++;
            $display("FAIL oor_up: got %h/%b expected 000100/001", o_cnt_val, o_tick);
        end
        apply(1'b1, pack3(0, 0, 15), 1'b1, 1'b0, 1'b0);
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (o_cnt_val !== pack3(0, 0, 9) || o_tick !== 3'b000) begin
            n_errors++;
            $display("FAIL oor_down: got %h/%b expected 000009/000", o_cnt_val, o_tick);
        end
        // Modulus 1 on stage 0 passes every advance straight to stage 1
        i_mod = pack3(24, 60, 1);
        apply(1'b1, pack3(0, 5, 0), 1'b1, 1'b0, 1'b0);
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(0, 6, 0) || o_tick !== 3'b001) begin
            n_errors++;
            $display("FAIL mod_one_passthru: got %h/%b expected 000600/001", o_cnt_val, o_tick);
        end
        i_mod = pack3(24, 60, 60);
    endtask

    task automatic test_priority();
        apply(1'b1, pack3(1, 2, 3), 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(1, 2, 3) || o_tick !== 3'b000) begin
            n_errors++;
            $display("FAIL load_over_tick: got %h/%b expected 010203/000", o_cnt_val, o_tick);
        end
        for (int i = 0; i < 10; i++) apply(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(1, 2, 3)) begin
            n_errors++;
            $display("FAIL run_en_freeze: got %h expected 010203", o_cnt_val);
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b1, pack3(22, 59, 50), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 24'h0, 1'b1, 1'b1, (i < 20) ? 1'b0 : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, pack3(0, 0, 59), 1'b1, 1'b0, 1'b0);
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (o_cnt_val !== 24'h0 || o_tick !== 3'b000) begin
            n_errors++;
            $display("FAIL async_reset: got %h/%b expected 000000/000", o_cnt_val, o_tick);
        end
        n_checks++;
        if (o_cnt_val_d !== 24'h0 || o_tick_d !== 3'b000) begin
            n_errors++;
            $display("FAIL async_reset_delayed: got %h/%b expected 000000/000", o_cnt_val_d, o_tick_d);
        end
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply(1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_cnt_val !== pack3(0, 0, 1)) begin
            n_errors++;
            $display("FAIL first_tick_after_reset: got %h expected 000001", o_cnt_val);
        end
    endtask

    initial begin
        i_run_en = 1'b1; i_tick = 1'b0; i_dir = 1'b0; i_load = 1'b0;
        i_load_val = 24'h0; i_mod = pack3(24, 60, 60);
        model_reset();
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_out_of_range();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
